// File: rtl/nes_paddle_ctrl.sv
// Paddle position controller: debounced-button edge pulses plus a per-frame
// IDLE/SLOW/FAST motion state machine with clamped vertical position.
module nes_paddle_ctrl #(
    parameter int INIT_Y      = 204,
    parameter int Y_MIN       = 32,
    parameter int Y_MAX       = 447,
    parameter int PAD_H       = 72,
    parameter int SLOW_VEL    = 2,
    parameter int FAST_VEL    = 6,
    parameter int HOLD_FRAMES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       start,
    input  logic       select,
    input  logic       refresh_tick,
    output logic [9:0] paddle_y,
    output logic       start_pulse,
    output logic       select_pulse,
    output logic       moving
);

    localparam int HW      = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
    localparam int Y_LIMIT = Y_MAX - PAD_H + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOW = 2'd1,
        FAST = 2'd2
    } state_t;

    state_t          state_r, state_nxt_s;
    logic            dir_r, dir_nxt_s;          // 1 = down
    logic [HW-1:0]   hold_r, hold_nxt_s, hold_inc_s;
    logic [9:0]      y_r, y_nxt_s;
    logic            start_q_r, select_q_r;
    logic            start_pulse_r, select_pulse_r, moving_r;
    logic            moving_nxt_s;
    logic            want_up_s, want_dn_s, req_s, select_rise_s;

    // One clamped step in 11-bit arithmetic so neither direction can wrap.
    function automatic logic [9:0] step_pos(input logic [9:0] y, input logic [10:0] vel,
                                            input logic dn);
        logic [10:0] y_ext;
        logic [10:0] res;
        y_ext = {1'b0, y};
        if (dn) begin
            res = y_ext + vel;
            if (res > 11'(Y_LIMIT)) begin
                res = 11'(Y_LIMIT);
            end else begin
                res = res;
            end
        end else begin
            if (y_ext < (11'(Y_MIN) + vel)) begin
                res = 11'(Y_MIN);
            end else begin
                res = y_ext - vel;
            end
        end
        return res[9:0];
    endfunction

    assign want_up_s     = up & ~down;
    assign want_dn_s     = down & ~up;
    assign req_s         = want_up_s | want_dn_s;
    assign select_rise_s = select & ~select_q_r;
    assign hold_inc_s    = (hold_r == HW'(HOLD_FRAMES)) ? hold_r : hold_r + 1'b1;

    // Motion state, direction, hold counter and position registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            dir_r   <= 1'b0;
            hold_r  <= '0;
            y_r     <= 10'(INIT_Y);
        end else begin
            state_r <= state_nxt_s;
            dir_r   <= dir_nxt_s;
            hold_r  <= hold_nxt_s;
            y_r     <= y_nxt_s;
        end
    end

    // Next-state logic; a select edge recenters and overrides any frame tick.
    always_comb begin
        state_nxt_s = state_r;
        dir_nxt_s   = dir_r;
        hold_nxt_s  = hold_r;
        y_nxt_s     = y_r;
        if (select_rise_s) begin
            state_nxt_s = IDLE;
            hold_nxt_s  = '0;
            y_nxt_s     = 10'(INIT_Y);
        end else if (refresh_tick) begin
            if (!req_s) begin
                state_nxt_s = IDLE;
                hold_nxt_s  = '0;
            end else begin
                case (state_r)
                    SLOW, FAST: begin
                        if (want_dn_s == dir_r) begin
                            if (state_r == FAST) begin
                                y_nxt_s = step_pos(y_r, 11'(FAST_VEL), dir_r);
                            end else begin
                                y_nxt_s    = step_pos(y_r, 11'(SLOW_VEL), dir_r);
                                hold_nxt_s = hold_inc_s;
                                if (hold_inc_s == HW'(HOLD_FRAMES)) begin
                                    state_nxt_s = FAST;
                                end else begin
                                    state_nxt_s = SLOW;
                                end
                            end
                        end else begin
                            y_nxt_s     = step_pos(y_r, 11'(SLOW_VEL), want_dn_s);
                            dir_nxt_s   = want_dn_s;
                            hold_nxt_s  = HW'(1);
                            state_nxt_s = SLOW;
                        end
                    end
                    default: begin
                        y_nxt_s     = step_pos(y_r, 11'(SLOW_VEL), want_dn_s);
                        dir_nxt_s   = want_dn_s;
                        hold_nxt_s  = HW'(1);
                        state_nxt_s = SLOW;
                    end
                endcase
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Output decode from the upcoming state so moving tracks the state register.
    always_comb begin
        moving_nxt_s = 1'b0;
        case (state_nxt_s)
            SLOW, FAST: moving_nxt_s = 1'b1;
            default:    moving_nxt_s = 1'b0;
        endcase
    end

    // Registered outputs and button edge-detect history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q_r      <= 1'b0;
            select_q_r     <= 1'b0;
            start_pulse_r  <= 1'b0;
            select_pulse_r <= 1'b0;
            moving_r       <= 1'b0;
        end else begin
            start_q_r      <= start;
            select_q_r     <= select;
            start_pulse_r  <= start & ~start_q_r;
            select_pulse_r <= select_rise_s;
            moving_r       <= moving_nxt_s;
        end
    end

    assign paddle_y     = y_r;
    assign start_pulse  = start_pulse_r;
    assign select_pulse = select_pulse_r;
    assign moving       = moving_r;

endmodule

// File: tb/tb_nes_paddle_ctrl.sv
// Scoreboard bench for nes_paddle_ctrl: a frame-level reference model queues
// expected outputs per clock; a monitor pops and compares after each edge.
module tb_nes_paddle_ctrl;

    localparam int INIT = 204;
    localparam int YLO  = 32;
    localparam int YHI  = 447 - 72 + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       up = 1'b0, down = 1'b0, start = 1'b0, select = 1'b0, refresh_tick = 1'b0;
    logic [9:0] paddle_y;
    logic       start_pulse, select_pulse, moving;

    typedef struct {
        int y;
        int mv;
        int sp;
        int sl;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: mode 0 idle, 1 slow, 2 fast; dir -1 up / +1 down.
    int m_y = INIT, m_mode = 0, m_dir = 0, m_cnt = 0, m_pst = 0, m_psl = 0;

    nes_paddle_ctrl dut (
        .clk(clk), .reset(reset), .up(up), .down(down), .start(start),
        .select(select), .refresh_tick(refresh_tick), .paddle_y(paddle_y),
        .start_pulse(start_pulse), .select_pulse(select_pulse), .moving(moving)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampy(input int v);
        if (v < YLO) return YLO;
        if (v > YHI) return YHI;
        return v;
    endfunction

    task automatic model_reset();
        m_y = INIT; m_mode = 0; m_dir = 0; m_cnt = 0; m_pst = 0; m_psl = 0;
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_push();
        exp_t e;
        int   want, sp, sl;
        sp = (start && !m_pst) ? 1 : 0;
        sl = (select && !m_psl) ? 1 : 0;
        m_pst = start;
        m_psl = select;
        want = (up && !down) ? -1 : ((down && !up) ? 1 : 0);
        if (sl == 1) begin
            m_y = INIT; m_mode = 0; m_cnt = 0;
        end else if (refresh_tick) begin
            if (want == 0) begin
                m_mode = 0; m_cnt = 0;
            end else if (m_mode == 0 || want != m_dir) begin
                m_y = clampy(m_y + want * 2); m_dir = want; m_cnt = 1; m_mode = 1;
            end else if (m_mode == 1) begin
                m_y = clampy(m_y + want * 2);
                if (m_cnt < 16) m_cnt++;
                if (m_cnt == 16) m_mode = 2;
            end else begin
                m_y = clampy(m_y + want * 6);
            end
        end
        e.y = m_y; e.mv = (m_mode != 0) ? 1 : 0; e.sp = sp; e.sl = sl;
        exp_q.push_back(e);
    endtask

    task automatic apply(input logic u, input logic d, input logic st, input logic se,
                         input logic tk);
        @(negedge clk);
        up = u; down = d; start = st; select = se; refresh_tick = tk;
        model_push();
    endtask

    // Assert reset mid-cycle, check the asynchronous clear, release before the edge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_y", int'(paddle_y), INIT);
        check("rst_moving", int'(moving), 0);
        check("rst_pulses", int'({start_pulse, select_pulse}), 0);
        #1;
        reset = 1'b0;
        model_reset();
        model_push();
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input logic u, input logic d, input int n);
        for (int i = 0; i < n; i++) begin
            apply(u, d, 1'b0, 1'b0, 1'b1);
            apply(u, d, 1'b0, 1'b0, 1'b0);
        end
        settle();
    endtask

    // Monitor: every clock edge with a pending expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_paddle_y", int'(paddle_y), e.y);
                check("sb_moving", int'(moving), e.mv);
                check("sb_start_pulse", int'(start_pulse), e.sp);
                check("sb_select_pulse", int'(select_pulse), e.sl);
            end
        end
    end

    initial begin
        int cnt;
        do_reset();
        ticks(1'b0, 1'b0, 5);
        check("idle_y", int'(paddle_y), 204);
        check("idle_moving", int'(moving), 0);

        ticks(1'b1, 1'b0, 16);
        check("hold16_y", int'(paddle_y), 172);
        ticks(1'b1, 1'b0, 1);
        check("fast_y", int'(paddle_y), 166);
        ticks(1'b0, 1'b0, 1);
        check("release_moving", int'(moving), 0);
        check("release_y", int'(paddle_y), 166);

        ticks(1'b0, 1'b1, 2);
        ticks(1'b0, 1'b0, 1);
        ticks(1'b1, 1'b0, 33);
        check("top_approach", int'(paddle_y), 36);
        ticks(1'b1, 1'b0, 1);
        check("top_clamp", int'(paddle_y), 32);
        ticks(1'b1, 1'b0, 2);
        check("top_hold", int'(paddle_y), 32);

        ticks(1'b0, 1'b1, 1);
        ticks(1'b0, 1'b0, 1);
        ticks(1'b0, 1'b1, 67);
        check("bot_approach", int'(paddle_y), 372);
        ticks(1'b0, 1'b1, 1);
        check("bot_clamp", int'(paddle_y), 376);
        ticks(1'b0, 1'b1, 2);
        check("bot_hold", int'(paddle_y), 376);

        ticks(1'b1, 1'b0, 1);
        check("reverse_y", int'(paddle_y), 374);
        ticks(1'b1, 1'b0, 1);
        check("reverse_slow", int'(paddle_y), 372);

        ticks(1'b0, 1'b0, 1);
        ticks(1'b1, 1'b1, 3);
        check("both_y", int'(paddle_y), 372);
        check("both_moving", int'(moving), 0);

        ticks(1'b1, 1'b0, 3);
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        settle();
        check("sel_pulse", int'(select_pulse), 1);
        check("sel_y", int'(paddle_y), 204);
        check("sel_moving", int'(moving), 0);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        check("sel_pulse_end", int'(select_pulse), 0);

        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            settle();
            cnt += int'(start_pulse);
        end
        check("start_pulse_count", cnt, 1);

        do_reset();
        settle();
        check("held_thru_reset", int'(start_pulse), 1);
        ticks(1'b0, 1'b1, 4);
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0),
                      1'($urandom_range(0, 3) == 0));
            end
        end

        repeat (3) @(negedge clk);
        check("queue_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
